fetch: RTL and testbench

FETCH -- requirements
Module: fetch

---
 rtl/cpu_params_pkg.sv | 7 +
 rtl/cpu_structs_pkg.sv | 19 +
 rtl/f2d_intf.sv | 12 +
 rtl/fetch_queue.sv | 50 +++++
 rtl/fetch.sv | 148 ++++++++++++++
 tb/tb_fetch.sv | 307 ++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/cpu_params_pkg.sv
// rtl/cpu_params_pkg.sv - CPU-wide constants shared by the front end
package cpu_params_pkg;

    localparam logic [31:0] RESET_PC              = 32'h0000_1000;
    localparam int          FETCH_Q_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/cpu_structs_pkg.sv
// rtl/cpu_structs_pkg.sv - pipeline payload structs and fetch state encoding
package cpu_structs_pkg;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } ipd_t;

    typedef struct packed {
        ipd_t ipd;
    } FET_2_DEC;

    typedef enum logic [1:0] {
        F_RESET = 2'd0,
        F_RUN   = 2'd1,
        F_HALT  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/f2d_intf.sv
// rtl/f2d_intf.sv - fetch-to-decode valid/rdy handshake carrying FET_2_DEC
interface F2D_intf;
    import cpu_structs_pkg::*;

    logic     valid;
    logic     rdy;
    FET_2_DEC data;

    modport master (output valid, output data, input rdy);
    modport slave  (input valid, input data, output rdy);

endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - power-of-two FIFO of generic elements with synchronous flush
module fetch_queue #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [31:0]
) (
    input  logic                   clk,
    input  logic                   flush,
    input  logic                   push,
    input  T                       push_data,
    input  logic                   pop,
    output T                       head_data,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    T              mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign full      = (count == CW'(DEPTH));
    assign do_pop    = pop && (count != '0);
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr];

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    full_push_check: assert property (@(posedge clk) disable iff (flush)
        !(push && full && !pop));

endmodule

// File: rtl/fetch.sv
// rtl/fetch.sv - instruction fetch with request credits, flush discard and decode queue
// Optional perf counters (perf_stall_cnt, perf_flush_cnt) under FETCH_PERF_EN.
module fetch
    import cpu_params_pkg::*;
    import cpu_structs_pkg::*;
#(
    parameter int FETCH_Q_DEPTH   = FETCH_Q_DEPTH_DEFAULT,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        cpu_halt,
    input  logic        pipe_flush,
    input  logic [31:0] branch_pc,
    output logic        ic_req_valid,
    output logic [31:0] ic_req_addr,
    input  logic        ic_req_rdy,
    input  logic        ic_rsp_valid,
    input  logic [31:0] ic_rsp_data,
    F2D_intf.master     F2D_bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);
    localparam int QCW = $clog2(FETCH_Q_DEPTH) + 1;
    localparam int CW  = 8;

    fetch_state_e   state;
    fetch_state_e   state_next;
    logic [31:0]    fetch_pc;
    logic [31:0]    rsp_pc;
    logic [CW-1:0]  outstanding;
    logic [CW-1:0]  discard_cnt;
    logic [CW-1:0]  in_use;
    logic [QCW-1:0] q_count;
    logic           req_fire;
    logic           rsp_live;
    logic           rsp_drop;
    logic           deliver;
    logic           q_flush;
    FET_2_DEC       push_data;
    FET_2_DEC       head_data;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state <= F_RESET;
        end else begin
            state <= state_next;
        end
    end

    // Only live (non-discarded) requests reserve queue slots.
    assign in_use = CW'(q_count) + outstanding;

    always_comb begin
        state_next   = state;
        ic_req_valid = 1'b0;
        case (state)
            F_RESET: state_next = F_RUN;
            F_RUN: begin
                if (cpu_halt) begin
                    state_next = F_HALT;
                end
                ic_req_valid = !reset_in && !pipe_flush
                            && (in_use < CW'(FETCH_Q_DEPTH))
                            && (outstanding < CW'(MAX_OUTSTANDING));
            end
            F_HALT: begin
                if (!cpu_halt) begin
                    state_next = F_RUN;
                end
            end
            default: state_next = F_RESET;
        endcase
    end

    assign ic_req_addr = fetch_pc;
    assign req_fire    = ic_req_valid && ic_req_rdy;
    assign rsp_live    = ic_rsp_valid && (discard_cnt == '0);
    assign rsp_drop    = ic_rsp_valid && (discard_cnt != '0);
    assign q_flush     = reset_in || pipe_flush;

    always_comb begin
        push_data          = '0;
        push_data.ipd.inst = ic_rsp_data;
        push_data.ipd.pc   = rsp_pc;
    end

    assign F2D_bus.valid = !reset_in && (q_count != '0);
    assign F2D_bus.data  = head_data;
    assign deliver       = F2D_bus.valid && F2D_bus.rdy;

    // On flush every live request still in flight turns into a discard.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard_cnt <= '0;
        end else if (pipe_flush) begin
            fetch_pc    <= branch_pc;
            rsp_pc      <= branch_pc;
            outstanding <= '0;
            discard_cnt <= outstanding + discard_cnt - CW'(ic_rsp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (rsp_live) begin
                rsp_pc <= rsp_pc + 32'd4;
            end
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_live);
            discard_cnt <= discard_cnt - CW'(rsp_drop);
        end
    end

    fetch_queue #(
        .DEPTH (FETCH_Q_DEPTH),
        .T     (FET_2_DEC)
    ) u_queue (
        .clk       (clk_in),
        .flush     (q_flush),
        .push      (rsp_live),
        .push_data (push_data),
        .pop       (deliver),
        .head_data (head_data),
        .count     (q_count)
    );

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (state == F_RUN && q_count == '0 && perf_stall_cnt != '1) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (pipe_flush && perf_flush_cnt != '1) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch.sv
// tb/tb_fetch.sv - directed self-checking bench for fetch with an in-order memory model
module tb_fetch;
    import cpu_params_pkg::*;
    import cpu_structs_pkg::*;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset_in;
    logic        cpu_halt;
    logic        pipe_flush;
    logic [31:0] branch_pc;
    logic        ic_req_valid;
    logic [31:0] ic_req_addr;
    logic        ic_req_rdy;
    logic        ic_rsp_valid;
    logic [31:0] ic_rsp_data;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    F2D_intf f2d ();

    fetch dut (
        .clk_in       (clk),
        .reset_in     (reset_in),
        .cpu_halt     (cpu_halt),
        .pipe_flush   (pipe_flush),
        .branch_pc    (branch_pc),
        .ic_req_valid (ic_req_valid),
        .ic_req_addr  (ic_req_addr),
        .ic_req_rdy   (ic_req_rdy),
        .ic_rsp_valid (ic_rsp_valid),
        .ic_rsp_data  (ic_rsp_data),
        .F2D_bus      (f2d)
`ifdef FETCH_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          flush_cycles = 0;
    logic        mem_hold = 1'b0;
    logic [31:0] exp_pc   = RESET_PC;
    logic [31:0] pend_addr [$];
    int          pend_cyc  [$];
    logic [31:0] req_log   [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic expect_next_pc(input string tag, input logic [31:0] pc);
        int n = 0;
        while (!f2d.valid && n < 10) begin
            step(1);
            sample();
            n++;
        end
        check({tag, "_valid"}, f2d.valid, 1);
        check(tag, f2d.data.ipd.pc, pc);
    endtask

    // Memory: in-order, one cycle minimum latency, stallable via mem_hold.
    initial begin
        ic_rsp_valid = 1'b0;
        ic_rsp_data  = '0;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            ic_rsp_valid = 1'b0;
            if (!mem_hold && pend_addr.size() > 0 && pend_cyc[0] < cyc) begin
                ic_rsp_valid = 1'b1;
                ic_rsp_data  = pend_addr.pop_front() ^ KEY;
                void'(pend_cyc.pop_front());
            end
        end
    end

    // Request capture and in-order delivery scoreboard.
    always @(negedge clk) begin
        if (reset_in) begin
            pend_addr.delete();
            pend_cyc.delete();
            exp_pc = RESET_PC;
        end else begin
            if (ic_req_valid && ic_req_rdy) begin
                pend_addr.push_back(ic_req_addr);
                pend_cyc.push_back(cyc);
                req_log.push_back(ic_req_addr);
            end
            if (f2d.valid && f2d.rdy) begin
                check("dlv_pc", f2d.data.ipd.pc, exp_pc);
                check("dlv_inst", f2d.data.ipd.inst, exp_pc ^ KEY);
                exp_pc = exp_pc + 32'd4;
            end
            if (pipe_flush) begin
                exp_pc = branch_pc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_in   = 1'b1;
        cpu_halt   = 1'b0;
        pipe_flush = 1'b0;
        branch_pc  = '0;
        ic_req_rdy = 1'b1;
        f2d.rdy    = 1'b1;

        step(3);
        sample();
        check("rst_req_valid", ic_req_valid, 0);
        check("rst_f2d_valid", f2d.valid, 0);
        check("rst_req_addr", ic_req_addr, RESET_PC);

        // Release: first delivery three cycles later, sequential requests.
        step(1);
        reset_in = 1'b0;
        req_log.delete();
        sample();
        n = 0;
        while (!f2d.valid && n < 10) begin
            step(1);
            sample();
            n++;
        end
        check("first_valid_latency", n, 3);
        check("first_pc", f2d.data.ipd.pc, RESET_PC);
        check("req_cnt_ge3", req_log.size() >= 3, 1);
        check("req0", req_log[0], RESET_PC);
        check("req1", req_log[1], RESET_PC + 32'd4);
        check("req2", req_log[2], RESET_PC + 32'd8);
        step(6);

        // Decode back-pressure fills the queue, then drains without gaps.
        f2d.rdy = 1'b0;
        step(20);
        sample();
        check("stall_qcount", dut.q_count, 4);
        check("stall_req_valid", ic_req_valid, 0);
        check("stall_f2d_valid", f2d.valid, 1);
        step(1);
        f2d.rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample();
            check("drain_no_gap", f2d.valid, 1);
            step(1);
        end

        // Two requests in flight, then flush: both stale responses dropped.
        mem_hold = 1'b1;
        step(8);
        sample();
        check("hold_outstanding", dut.outstanding, 2);
        check("hold_req_valid", ic_req_valid, 0);
        step(1);
        pipe_flush = 1'b1;
        branch_pc  = 32'h0000_0100;
        flush_cycles++;
        step(1);
        pipe_flush = 1'b0;
        mem_hold   = 1'b0;
        sample();
        check("flush_q_empty", f2d.valid, 0);
        check("flush_discard2", dut.discard_cnt, 2);
        expect_next_pc("flush_pc", 32'h0000_0100);

        // Flush coinciding with a response: only one stale left to drop.
        step(4);
        mem_hold = 1'b1;
        step(8);
        sample();
        check("hold2_outstanding", dut.outstanding, 2);
        step(1);
        pipe_flush = 1'b1;
        branch_pc  = 32'h0000_0200;
        mem_hold   = 1'b0;
        flush_cycles++;
        sample();
        check("flush_rsp_same_cycle", ic_rsp_valid, 1);
        step(1);
        pipe_flush = 1'b0;
        sample();
        check("discard_one", dut.discard_cnt, 1);
        check("flush2_q_empty", f2d.valid, 0);
        step(1);
        sample();
        check("discard_zero", dut.discard_cnt, 0);
        expect_next_pc("flush2_pc", 32'h0000_0200);

        // Halt with one request outstanding.
        step(1);
        ic_req_rdy = 1'b0;
        step(8);
        pipe_flush = 1'b1;
        branch_pc  = 32'h0000_0300;
        flush_cycles++;
        step(1);
        pipe_flush = 1'b0;
        ic_req_rdy = 1'b1;
        cpu_halt   = 1'b1;
        mem_hold   = 1'b1;
        sample();
        check("halt_req_valid", ic_req_valid, 1);
        check("halt_req_addr", ic_req_addr, 32'h0000_0300);
        for (int i = 0; i < 2; i++) begin
            step(1);
            sample();
            check("halt_no_req", ic_req_valid, 0);
        end
        step(1);
        mem_hold = 1'b0;
        sample();
        check("halt_no_req", ic_req_valid, 0);
        check("halt_rsp", ic_rsp_valid, 1);
        step(1);
        sample();
        check("halt_dlv_valid", f2d.valid, 1);
        check("halt_dlv_pc", f2d.data.ipd.pc, 32'h0000_0300);
        step(1);
        cpu_halt = 1'b0;
        sample();
        check("halt_exit_no_req", ic_req_valid, 0);
        step(1);
        sample();
        check("resume_req_valid", ic_req_valid, 1);
        check("resume_req_addr", ic_req_addr, 32'h0000_0304);

        // Address wrap at the top of the address space.
        step(1);
        pipe_flush = 1'b1;
        branch_pc  = 32'hFFFF_FFFC;
        flush_cycles++;
        step(1);
        pipe_flush = 1'b0;
        sample();
        check("wrap_req_valid0", ic_req_valid, 1);
        check("wrap_req_addr0", ic_req_addr, 32'hFFFF_FFFC);
        step(1);
        sample();
        check("wrap_req_valid1", ic_req_valid, 1);
        check("wrap_req_addr1", ic_req_addr, 32'h0000_0000);
        step(8);
`ifdef FETCH_PERF_EN
        sample();
        check("perf_flush_cnt", perf_flush_cnt, flush_cycles);
`endif

        // Reset mid-operation clears everything on the next edge.
        step(1);
        reset_in = 1'b1;
        step(1);
        sample();
        check("midrst_req_valid", ic_req_valid, 0);
        check("midrst_f2d_valid", f2d.valid, 0);
        check("midrst_req_addr", ic_req_addr, RESET_PC);
        check("midrst_qcount", dut.q_count, 0);
        check("midrst_outstanding", dut.outstanding, 0);
`ifdef FETCH_PERF_EN
        check("midrst_perf_flush", perf_flush_cnt, 0);
`endif
        step(1);
        reset_in = 1'b0;
        step(1);
        sample();
        check("postrst_req_valid", ic_req_valid, 1);
        check("postrst_req_addr", ic_req_addr, RESET_PC);
        expect_next_pc("postrst_pc", RESET_PC);
        step(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
